// File: rtl/physical_regfile_mp.sv
// Multi-port physical register file with per-register ready bits and a registered not-ready count.
// Optional define PRF_WB_BYPASS_EN: same-cycle writeback/clear forwarding onto every read port.

module prf_rd_port #(
    parameter int XLEN     = 64,
    parameter int PREG_NUM = 64,
    parameter int PREG_W   = 6
`ifdef PRF_WB_BYPASS_EN
    ,
    parameter int WR_PORTS  = 3,
    parameter int CLR_PORTS = 2
`endif
) (
    input  logic [PREG_W-1:0]                addr,
    input  logic [PREG_NUM-1:0][XLEN-1:0]    regs,
    input  logic [PREG_NUM-1:0]              ready,
`ifdef PRF_WB_BYPASS_EN
    input  logic [WR_PORTS-1:0]              wr_valid,
    input  logic [WR_PORTS-1:0][PREG_W-1:0]  wr_addr,
    input  logic [WR_PORTS-1:0][XLEN-1:0]    wr_data,
    input  logic [CLR_PORTS-1:0]             clr_valid,
    input  logic [CLR_PORTS-1:0][PREG_W-1:0] clr_addr,
`endif
    output logic [XLEN-1:0]                  data,
    output logic                             rdy
);

`ifdef PRF_WB_BYPASS_EN
    logic hit;

    // Later write ports override earlier ones; a matching write masks any clear.
    always_comb begin
        data = regs[addr];
        rdy  = ready[addr];
        hit  = 1'b0;
        for (int j = 0; j < WR_PORTS; j++) begin
            if (wr_valid[j] && wr_addr[j] == addr && addr != '0) begin
                data = wr_data[j];
                rdy  = 1'b1;
                hit  = 1'b1;
            end
        end
        for (int c = 0; c < CLR_PORTS; c++) begin
            if (!hit && clr_valid[c] && clr_addr[c] == addr && addr != '0)
                rdy = 1'b0;
        end
    end
`else
    assign data = regs[addr];
    assign rdy  = ready[addr];
`endif

endmodule

module physical_regfile_mp #(
    parameter int XLEN      = 64,
    parameter int PREG_NUM  = 64,
    parameter int PREG_W    = 6,
    parameter int RD_PORTS  = 4,
    parameter int WR_PORTS  = 3,
    parameter int CLR_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [RD_PORTS*PREG_W-1:0]    rd_addr,
    output logic [RD_PORTS*XLEN-1:0]      rd_data,
    output logic [RD_PORTS-1:0]           rd_ready,
    input  logic [WR_PORTS-1:0]           wr_valid,
    input  logic [WR_PORTS*PREG_W-1:0]    wr_addr,
    input  logic [WR_PORTS*XLEN-1:0]      wr_data,
    input  logic [CLR_PORTS-1:0]          clr_valid,
    input  logic [CLR_PORTS*PREG_W-1:0]   clr_addr,
    output logic [PREG_W:0]               pending_cnt
);

    logic [RD_PORTS-1:0][PREG_W-1:0]  rd_addr_a;
    logic [RD_PORTS-1:0][XLEN-1:0]    rd_data_a;
    logic [WR_PORTS-1:0][PREG_W-1:0]  wr_addr_a;
    logic [WR_PORTS-1:0][XLEN-1:0]    wr_data_a;
    logic [CLR_PORTS-1:0][PREG_W-1:0] clr_addr_a;

    assign rd_addr_a  = rd_addr;
    assign wr_addr_a  = wr_addr;
    assign wr_data_a  = wr_data;
    assign clr_addr_a = clr_addr;
    assign rd_data    = rd_data_a;

    logic [PREG_NUM-1:0][XLEN-1:0] regs_q, regs_d;
    logic [PREG_NUM-1:0]           ready_q, ready_d, wr_hit;
    logic [PREG_W:0]               pend_q, pend_d;

    // P0 is never written and its ready bit is pinned, so it never counts as pending.
    always_comb begin
        regs_d  = regs_q;
        ready_d = ready_q;
        wr_hit  = '0;
        for (int j = 0; j < WR_PORTS; j++) begin
            if (wr_valid[j] && wr_addr_a[j] != '0) begin
                regs_d[wr_addr_a[j]] = wr_data_a[j];
                wr_hit[wr_addr_a[j]] = 1'b1;
            end
        end
        for (int c = 0; c < CLR_PORTS; c++) begin
            if (clr_valid[c])
                ready_d[clr_addr_a[c]] = 1'b0;
        end
        ready_d    = ready_d | wr_hit;
        ready_d[0] = 1'b1;
    end

    // Count over the next-state vector so the registered count tracks the array with no lag.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < PREG_NUM; i++)
            pend_d = pend_d + {{PREG_W{1'b0}}, ~ready_d[i]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q  <= '0;
            ready_q <= '1;
            pend_q  <= '0;
        end else begin
            regs_q  <= regs_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
        end
    end

    assign pending_cnt = pend_q;

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
`ifdef PRF_WB_BYPASS_EN
        prf_rd_port #(
            .XLEN(XLEN), .PREG_NUM(PREG_NUM), .PREG_W(PREG_W),
            .WR_PORTS(WR_PORTS), .CLR_PORTS(CLR_PORTS)
        ) u_rd (
            .addr      (rd_addr_a[k]),
            .regs      (regs_q),
            .ready     (ready_q),
            .wr_valid  (wr_valid),
            .wr_addr   (wr_addr_a),
            .wr_data   (wr_data_a),
            .clr_valid (clr_valid),
            .clr_addr  (clr_addr_a),
            .data      (rd_data_a[k]),
            .rdy       (rd_ready[k])
        );
`else
        prf_rd_port #(
            .XLEN(XLEN), .PREG_NUM(PREG_NUM), .PREG_W(PREG_W)
        ) u_rd (
            .addr  (rd_addr_a[k]),
            .regs  (regs_q),
            .ready (ready_q),
            .data  (rd_data_a[k]),
            .rdy   (rd_ready[k])
        );
`endif
    end

endmodule

// File: tb/tb_physical_regfile_mp.sv
// Self-checking bench for physical_regfile_mp: directed table, hand sequences, random vs model.
// Honours PRF_WB_BYPASS_EN for the expected same-cycle read behaviour.

module tb_physical_regfile_mp;
    localparam int XLEN = 64, PREG_NUM = 64, PREG_W = 6;
    localparam int RD_PORTS = 4, WR_PORTS = 3, CLR_PORTS = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [RD_PORTS-1:0][PREG_W-1:0]  rd_addr;
    logic [RD_PORTS-1:0][XLEN-1:0]    rd_data;
    logic [RD_PORTS-1:0]              rd_ready;
    logic [WR_PORTS-1:0]              wr_valid;
    logic [WR_PORTS-1:0][PREG_W-1:0]  wr_addr;
    logic [WR_PORTS-1:0][XLEN-1:0]    wr_data;
    logic [CLR_PORTS-1:0]             clr_valid;
    logic [CLR_PORTS-1:0][PREG_W-1:0] clr_addr;
    logic [PREG_W:0]                  pending_cnt;

    physical_regfile_mp #(
        .XLEN(XLEN), .PREG_NUM(PREG_NUM), .PREG_W(PREG_W),
        .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS), .CLR_PORTS(CLR_PORTS)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_valid(clr_valid), .clr_addr(clr_addr),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

`ifdef PRF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Reference state: plain arrays updated by the architectural rules.
    logic [XLEN-1:0] m_data [PREG_NUM];
    bit              m_rdy  [PREG_NUM];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < PREG_NUM; i++) if (!m_rdy[i]) n++;
        return n;
    endfunction

    task automatic check_model(input string tag);
        for (int k = 0; k < RD_PORTS; k++) begin
            int a;
            logic [XLEN-1:0] ed;
            bit er, wr_match, clr_match;
            a = int'(rd_addr[k]);
            ed = m_data[a];
            er = m_rdy[a];
            wr_match = 1'b0;
            clr_match = 1'b0;
            if (BYP && a != 0) begin
                for (int j = 0; j < WR_PORTS; j++)
                    if (wr_valid[j] && int'(wr_addr[j]) == a) begin ed = wr_data[j]; wr_match = 1'b1; end
                for (int c = 0; c < CLR_PORTS; c++)
                    if (clr_valid[c] && int'(clr_addr[c]) == a) clr_match = 1'b1;
                if (wr_match) er = 1'b1;
                else if (clr_match) er = 1'b0;
            end
            chk($sformatf("%s rd_data[%0d]", tag, k), rd_data[k], ed);
            chk($sformatf("%s rd_ready[%0d]", tag, k), 64'(rd_ready[k]), 64'(er));
        end
        chk($sformatf("%s pending_cnt", tag), 64'(pending_cnt), 64'(m_pending()));
    endtask

    task automatic model_edge();
        bit written [PREG_NUM];
        if (reset) begin
            for (int i = 0; i < PREG_NUM; i++) begin m_data[i] = '0; m_rdy[i] = 1'b1; end
            return;
        end
        for (int i = 0; i < PREG_NUM; i++) written[i] = 1'b0;
        for (int j = 0; j < WR_PORTS; j++)
            if (wr_valid[j] && wr_addr[j] != 0) begin
                m_data[wr_addr[j]] = wr_data[j];
                written[wr_addr[j]] = 1'b1;
            end
        for (int c = 0; c < CLR_PORTS; c++)
            if (clr_valid[c] && clr_addr[c] != 0 && !written[clr_addr[c]]) m_rdy[clr_addr[c]] = 1'b0;
        for (int i = 0; i < PREG_NUM; i++) if (written[i]) m_rdy[i] = 1'b1;
    endtask

    task automatic cycle(input string tag, input bit do_chk);
        @(negedge clk);
        if (do_chk) check_model(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        clr_valid = '0; clr_addr = '0;
    endtask

    typedef struct packed {
        logic [WR_PORTS-1:0]              wv;
        logic [WR_PORTS-1:0][PREG_W-1:0]  wa;
        logic [WR_PORTS-1:0][XLEN-1:0]    wd;
        logic [CLR_PORTS-1:0]             cv;
        logic [CLR_PORTS-1:0][PREG_W-1:0] ca;
        logic [PREG_W-1:0]                chk_addr;
        logic [XLEN-1:0]                  exp_d;
        logic                             exp_r;
        logic [PREG_W:0]                  exp_cnt;
    } vec_t;

    function automatic vec_t mkv(input logic [2:0] wv, input logic [5:0] wa2, wa1, wa0,
                                 input logic [63:0] wd2, wd1, wd0,
                                 input logic [1:0] cv, input logic [5:0] ca1, ca0,
                                 input logic [5:0] ca_chk, input logic [63:0] ed,
                                 input logic er, input logic [6:0] ec);
        vec_t v;
        v.wv = wv; v.wa = {wa2, wa1, wa0}; v.wd = {wd2, wd1, wd0};
        v.cv = cv; v.ca = {ca1, ca0};
        v.chk_addr = ca_chk; v.exp_d = ed; v.exp_r = er; v.exp_cnt = ec;
        return v;
    endfunction

    function automatic logic [5:0] raddr();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
        return 6'($urandom_range(0, 11));
    endfunction

    vec_t tv [9];

    initial begin
        // Expected values are observed on the idle cycle following each vector.
        tv[0] = mkv(3'b000, 0, 0, 0, 0, 0, 0,        2'b11, 9, 5,   5, 64'h0,    1'b0, 2);
        tv[1] = mkv(3'b000, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0,   9, 64'h0,    1'b0, 2);
        tv[2] = mkv(3'b010, 0, 5, 0, 0, 64'hDEAD, 0, 2'b00, 0, 0,   5, 64'hDEAD, 1'b1, 1);
        tv[3] = mkv(3'b101, 7, 0, 7, 64'h22, 0, 64'h11, 2'b00, 0, 0, 7, 64'h22,  1'b1, 1);
        tv[4] = mkv(3'b001, 0, 0, 0, 0, 0, 64'hFFFF, 2'b01, 0, 0,   0, 64'h0,    1'b1, 1);
        tv[5] = mkv(3'b010, 0, 12, 0, 0, 64'h1212, 0, 2'b01, 0, 12, 12, 64'h1212, 1'b1, 1);
        tv[6] = mkv(3'b000, 0, 0, 0, 0, 0, 0,        2'b11, 12, 12, 12, 64'h1212, 1'b0, 2);
        tv[7] = mkv(3'b100, 9, 0, 0, 64'h99, 0, 0,   2'b10, 12, 0,  9, 64'h99,   1'b1, 1);
        tv[8] = mkv(3'b001, 0, 0, 12, 0, 0, 64'h5,   2'b01, 0, 5,   5, 64'hDEAD, 1'b0, 1);

        idle();
        rd_addr = '0;
        reset = 1'b1;
        cycle("rst", 1'b0);
        reset = 1'b0;
        rd_addr = {6'd63, 6'd33, 6'd1, 6'd0};
        @(negedge clk);
        for (int k = 0; k < RD_PORTS; k++) begin
            chk($sformatf("reset rd_data[%0d]", k), rd_data[k], 64'h0);
            chk($sformatf("reset rd_ready[%0d]", k), 64'(rd_ready[k]), 64'h1);
        end
        chk("reset pending_cnt", 64'(pending_cnt), 64'h0);
        @(posedge clk); model_edge(); #1;

        for (int v = 0; v < 9; v++) begin
            wr_valid = tv[v].wv; wr_addr = tv[v].wa; wr_data = tv[v].wd;
            clr_valid = tv[v].cv; clr_addr = tv[v].ca;
            rd_addr = {RD_PORTS{tv[v].chk_addr}};
            cycle($sformatf("vec%0d", v), 1'b1);
            idle();
            @(negedge clk);
            for (int k = 0; k < RD_PORTS; k++) begin
                chk($sformatf("tbl%0d rd_data[%0d]", v, k), rd_data[k], tv[v].exp_d);
                chk($sformatf("tbl%0d rd_ready[%0d]", v, k), 64'(rd_ready[k]), 64'(tv[v].exp_r));
            end
            chk($sformatf("tbl%0d pending_cnt", v), 64'(pending_cnt), 64'(tv[v].exp_cnt));
            @(posedge clk); model_edge(); #1;
        end

        // Same-cycle visibility of a write and of a clear on preg 3.
        idle();
        wr_valid = 3'b001; wr_addr[0] = 6'd3; wr_data[0] = 64'h3333;
        cycle("pre3", 1'b1);
        idle();
        wr_valid = 3'b001; wr_addr[0] = 6'd3; wr_data[0] = 64'hABCD;
        rd_addr = {6'd0, 6'd1, 6'd2, 6'd3};
        @(negedge clk);
        chk("byp same-cycle data", rd_data[0], BYP ? 64'hABCD : 64'h3333);
        chk("byp same-cycle ready", 64'(rd_ready[0]), 64'h1);
        check_model("byp wr");
        @(posedge clk); model_edge(); #1;
        idle();
        clr_valid = 2'b10; clr_addr[1] = 6'd3;
        @(negedge clk);
        chk("byp next-cycle data", rd_data[0], 64'hABCD);
        chk("byp clr ready", 64'(rd_ready[0]), BYP ? 64'h0 : 64'h1);
        check_model("byp clr");
        @(posedge clk); model_edge(); #1;

        // Reset wins over concurrent writes and clears.
        idle();
        reset = 1'b1;
        wr_valid = 3'b001; wr_addr[0] = 6'd20; wr_data[0] = 64'h77;
        clr_valid = 2'b01; clr_addr[0] = 6'd21;
        cycle("midrst", 1'b0);
        reset = 1'b0;
        idle();
        rd_addr = {6'd21, 6'd20, 6'd5, 6'd3};
        @(negedge clk);
        for (int k = 0; k < RD_PORTS; k++) begin
            chk($sformatf("midrst rd_data[%0d]", k), rd_data[k], 64'h0);
            chk($sformatf("midrst rd_ready[%0d]", k), 64'(rd_ready[k]), 64'h1);
        end
        chk("midrst pending_cnt", 64'(pending_cnt), 64'h0);
        @(posedge clk); model_edge(); #1;

        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < RD_PORTS; k++) rd_addr[k] = raddr();
            wr_valid = WR_PORTS'($urandom);
            for (int j = 0; j < WR_PORTS; j++) begin
                wr_addr[j] = raddr();
                wr_data[j] = {$urandom, $urandom};
            end
            clr_valid = CLR_PORTS'($urandom);
            for (int c = 0; c < CLR_PORTS; c++) clr_addr[c] = raddr();
            cycle("rnd", 1'b1);
        end
        reset = 1'b0;
        idle();
        cycle("final", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
